// File: rtl/fun_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fun_ctrl_pkg
// Shared definitions for the function-block sweep controller:
//   state_e      - controller state encoding (IDLE, RUN, FINISH)
//   DEF_N_IN     - default number of function inputs
//   DEF_TABLE_W  - derived truth-table width, 2^DEF_N_IN
//   DEF_CNT_W    - derived mismatch-counter width, DEF_N_IN+1
// -----------------------------------------------------------------------------
package fun_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int unsigned DEF_N_IN    = 3;
    localparam int unsigned DEF_TABLE_W = 1 << DEF_N_IN;
    localparam int unsigned DEF_CNT_W   = DEF_N_IN + 1;

endpackage

// File: rtl/fun_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// fun_sweep_ctrl
// Drives every input combination of a combinational function block in
// ascending order, samples F after a settle time, builds the truth table and
// compares it with an expected table latched at start.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   sweep request, honoured only in IDLE
//   abort        in   cancel a sweep in progress
//   expected     in   expected truth table (bit i = F for input index i)
//   dut_out      in   F from the function block
//   dut_in       out  input combination to the function block (MSB = A)
//   busy         out  sweep in progress
//   done         out  one-cycle pulse at sweep completion
//   table_out    out  captured truth table
//   pass         out  captured table equals expected latch
//   mismatch_cnt out  number of differing bits
// -----------------------------------------------------------------------------
module fun_sweep_ctrl
    import fun_ctrl_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [(2**N_IN)-1:0]  expected,
    input  logic                  dut_out,
    output logic [N_IN-1:0]       dut_in,
    output logic                  busy,
    output logic                  done,
    output logic [(2**N_IN)-1:0]  table_out,
    output logic                  pass,
    output logic [N_IN:0]         mismatch_cnt
);

    localparam int unsigned TABLE_W  = 1 << N_IN;
    localparam int unsigned CNT_W    = N_IN + 1;
    localparam logic [3:0]  SETTLE_V = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TABLE_W - 1);

    state_e             state_q;
    logic [TABLE_W-1:0] exp_q;
    logic [TABLE_W-1:0] table_q;
    logic [TABLE_W-1:0] table_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [N_IN-1:0]    idx_q;
    logic [3:0]         settle_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;

    // Sample-edge values: table with the current bit captured, and the
    // mismatch count including the current comparison.
    always_comb begin
        table_d         = table_q;
        table_d[idx_q]  = dut_out;
        cnt_d           = cnt_q + CNT_W'(dut_out != exp_q[idx_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            table_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        exp_q    <= expected;
                        table_q  <= '0;
                        cnt_q    <= '0;
                        pass_q   <= 1'b0;
                        idx_q    <= '0;
                        settle_q <= SETTLE_V;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        table_q <= '0;
                        cnt_q   <= '0;
                        pass_q  <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (settle_q != 4'd0) begin
                        settle_q <= settle_q - 4'd1;
                    end else begin
                        table_q <= table_d;
                        cnt_q   <= cnt_d;
                        if (idx_q != LAST_IDX) begin
                            idx_q    <= idx_q + N_IN'(1);
                            settle_q <= SETTLE_V;
                        end else begin
                            // pass uses the count including the last sample so
                            // it is already valid in the done cycle.
                            pass_q  <= (cnt_d == '0);
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_in       = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_out    = table_q;
    assign pass         = pass_q;
    assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_fun_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fun_sweep_ctrl
// Two controller instances (SETTLE=1 and SETTLE=0) each drive a reference
// function block F = (A & B) | C. Expected sweep results are queued when a
// start is accepted; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_fun_sweep_ctrl;

    localparam int unsigned NI = 3;
    localparam int unsigned TW = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst1_n, start1, abort1, f1, busy1, done1, pass1;
    logic [TW-1:0] exp1, tbl1;
    logic [NI-1:0] din1;
    logic [CW-1:0] cnt1;

    logic          rst0_n, start0, abort0, f0, busy0, done0, pass0;
    logic [TW-1:0] exp0, tbl0;
    logic [NI-1:0] din0;
    logic [CW-1:0] cnt0;

    // Reference function blocks: F = (A & B) | C
    assign f1 = (din1[2] & din1[1]) | din1[0];
    assign f0 = (din0[2] & din0[1]) | din0[0];

    fun_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .abort(abort1),
        .expected(exp1), .dut_out(f1), .dut_in(din1), .busy(busy1),
        .done(done1), .table_out(tbl1), .pass(pass1), .mismatch_cnt(cnt1)
    );

    fun_sweep_ctrl #(.N_IN(3), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .start(start0), .abort(abort0),
        .expected(exp0), .dut_out(f0), .dut_in(din0), .busy(busy0),
        .done(done0), .table_out(tbl0), .pass(pass0), .mismatch_cnt(cnt0)
    );

    typedef struct {
        logic [TW-1:0] tbl;
        logic          ps;
        logic [CW-1:0] cnt;
        int            due;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) check("s1_unexpected_done", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("s1_table", 32'(tbl1), 32'(e.tbl));
                check("s1_mismatch_cnt", 32'(cnt1), 32'(e.cnt));
                check("s1_pass", 32'(pass1), 32'(e.ps));
                check("s1_done_cycle", cyc, e.due);
            end
        end
        if (done0) begin
            if (q0.size() == 0) check("s0_unexpected_done", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("s0_table", 32'(tbl0), 32'(e.tbl));
                check("s0_mismatch_cnt", 32'(cnt0), 32'(e.cnt));
                check("s0_pass", 32'(pass0), 32'(e.ps));
                check("s0_done_cycle", cyc, e.due);
            end
        end
    end

    task automatic accept1(input logic [TW-1:0] e, output int acc);
        @(negedge clk);
        exp1 = e; start1 = 1'b1;
        @(posedge clk); #1;
        acc = cyc; start1 = 1'b0;
        check("s1_busy_after_start", 32'(busy1), 32'd1);
    endtask

    task automatic accept0(input logic [TW-1:0] e, output int acc);
        @(negedge clk);
        exp0 = e; start0 = 1'b1;
        @(posedge clk); #1;
        acc = cyc; start0 = 1'b0;
        check("s0_busy_after_start", 32'(busy0), 32'd1);
    endtask

    // Returns one edge after the done cycle, i.e. with the DUT back in IDLE.
    task automatic wait_done1(input int maxc, input string name);
        int k;
        k = 0;
        while (!done1 && k < maxc) begin @(negedge clk); k++; end
        if (!done1) check({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done0(input int maxc, input string name);
        int k;
        k = 0;
        while (!done0 && k < maxc) begin @(negedge clk); k++; end
        if (!done0) check({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic sweep1(input logic [TW-1:0] e, input logic [TW-1:0] t,
                          input logic ps, input logic [CW-1:0] c, input bit steps);
        int acc;
        accept1(e, acc);
        q1.push_back('{t, ps, c, acc + 16});
        if (steps) begin
            for (int k = 0; k < 16; k++) begin
                check("s1_dut_in_step", 32'(din1), k >> 1);
                @(posedge clk); #1;
            end
        end
        wait_done1(40, "s1_sweep");
    endtask

    task automatic sweep0(input logic [TW-1:0] e, input logic [TW-1:0] t,
                          input logic ps, input logic [CW-1:0] c, input bit steps);
        int acc;
        accept0(e, acc);
        q0.push_back('{t, ps, c, acc + 8});
        if (steps) begin
            for (int k = 0; k < 8; k++) begin
                check("s0_dut_in_step", 32'(din0), k);
                @(posedge clk); #1;
            end
        end
        wait_done0(30, "s0_sweep");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
        int k;
        rst1_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; exp1 = '0;
        rst0_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; exp0 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("s1_reset_outputs", 32'({busy1, done1, pass1, din1, tbl1, cnt1}), 32'd0);
        check("s0_reset_outputs", 32'({busy0, done0, pass0, din0, tbl0, cnt0}), 32'd0);
        @(negedge clk);
        rst1_n = 1'b1; rst0_n = 1'b1;
        @(posedge clk); #1;
        check("s1_idle_after_reset", 32'(busy1), 32'd0);

        // Nominal sweep with dut_in stepping
        sweep1(8'hEA, 8'hEA, 1'b1, 4'd0, 1'b1);

        // Asynchronous reset mid-clock clears held results at once
        @(posedge clk); #3;
        rst1_n = 1'b0;
        #1;
        check("s1_async_reset", 32'({busy1, done1, pass1, din1, tbl1, cnt1}), 32'd0);
        @(negedge clk);
        rst1_n = 1'b1;

        // Mismatch cases
        sweep1(8'hEB, 8'hEA, 1'b0, 4'd1, 1'b0);
        sweep1(8'h15, 8'hEA, 1'b0, 4'd8, 1'b0);

        // start while busy is ignored; start held through FINISH is ignored
        accept1(8'hEA, acc);
        q1.push_back('{8'hEA, 1'b1, 4'd0, acc + 16});
        repeat (5) begin @(posedge clk); #1; end
        start1 = 1'b1; exp1 = 8'h00;
        wait_done1(40, "s1_handshake");
        start1 = 1'b0;
        check("s1_no_restart_after_finish", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        check("s1_still_idle", 32'(busy1), 32'd0);

        // Abort at dut_in = 3
        accept1(8'hEA, acc);
        k = 0;
        while (din1 != 3'd3 && k < 20) begin @(posedge clk); #1; k++; end
        check("s1_reach_dut_in3", 32'(din1), 32'd3);
        @(negedge clk);
        abort1 = 1'b1;
        @(posedge clk); #1;
        abort1 = 1'b0;
        check("s1_abort_outputs", 32'({busy1, done1, pass1, din1, tbl1, cnt1}), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("s1_abort_idle", 32'(busy1), 32'd0);
        sweep1(8'hEA, 8'hEA, 1'b1, 4'd0, 1'b0);

        // SETTLE=0 instance
        sweep0(8'hEA, 8'hEA, 1'b1, 4'd0, 1'b1);
        accept0(8'hEA, acc);
        k = 0;
        while (din0 != 3'd5 && k < 20) begin @(posedge clk); #1; k++; end
        check("s0_reach_dut_in5", 32'(din0), 32'd5);
        #2;
        rst0_n = 1'b0;
        #1;
        check("s0_reset_midsweep", 32'({busy0, done0, pass0, din0, tbl0, cnt0}), 32'd0);
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("s0_idle_after_reset", 32'(busy0), 32'd0);

        @(negedge clk);
        check("s1_scoreboard_drained", q1.size(), 32'd0);
        check("s0_scoreboard_drained", q0.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
